// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_checker
//  Description : Self-synchronising checker for the LFSR word stream. Seeds
//                its predictor from received data, declares lock after a run
//                of correct predictions, then free-runs and counts mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_checker #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b1001,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 3,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int               c_GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int               c_BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [WIDTH-1:0]    r_expected, w_expected_nxt;
    logic [c_GOOD_W-1:0] r_good_run, w_good_run_nxt;
    logic [c_BAD_W-1:0]  r_bad_run,  w_bad_run_nxt;
    logic                r_locked;
    logic                r_err_pulse, w_err_pulse_nxt;
    logic [CNT_W-1:0]    r_err_count, w_err_count_nxt;

    logic                w_match;
    logic                w_word_zero;
    logic [c_GOOD_W-1:0] w_good_inc;
    logic [c_BAD_W-1:0]  w_bad_inc;

    // Successor of a word in the LFSR sequence: shift left, feedback into LSB.
    function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ^(w & TAPS)};
    endfunction

    assign w_match     = (data_in == r_expected);
    assign w_word_zero = (data_in == '0);
    assign w_good_inc  = r_good_run + c_GOOD_W'(1);
    assign w_bad_inc   = r_bad_run + c_BAD_W'(1);

    // Next-state, predictor, run counters and error statistics.
    always_comb begin
        w_state_nxt     = r_state;
        w_expected_nxt  = r_expected;
        w_good_run_nxt  = r_good_run;
        w_bad_run_nxt   = r_bad_run;
        w_err_pulse_nxt = 1'b0;
        w_err_count_nxt = r_err_count;

        if (in_valid) begin
            case (r_state)
                S_SEARCH: begin
                    // All-zero is the LFSR lock-up word and can never seed.
                    if (!w_word_zero) begin
                        w_expected_nxt = f_next(data_in);
                        w_good_run_nxt = '0;
                        w_state_nxt    = S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (w_match) begin
                        w_good_run_nxt = w_good_inc;
                        w_expected_nxt = f_next(data_in);
                        if (w_good_inc == c_GOOD_W'(LOCK_CNT)) begin
                            w_state_nxt   = S_LOCKED;
                            w_bad_run_nxt = '0;
                        end
                    end else if (!w_word_zero) begin
                        w_expected_nxt = f_next(data_in);
                        w_good_run_nxt = '0;
                    end else begin
                        w_state_nxt = S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    // Free-running predictor: a corrupted word costs one error only.
                    w_expected_nxt = f_next(r_expected);
                    if (w_match) begin
                        w_bad_run_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_count != c_CNT_MAX) begin
                            w_err_count_nxt = r_err_count + CNT_W'(1);
                        end
                        w_bad_run_nxt = w_bad_inc;
                        if (w_bad_inc == c_BAD_W'(UNLOCK_CNT)) begin
                            w_state_nxt    = S_SEARCH;
                            w_good_run_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_SEARCH;
                end
            endcase
        end

        // Clear beats a coincident increment; the error pulse is unaffected.
        if (clr_cnt) begin
            w_err_count_nxt = '0;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SEARCH;
            r_expected  <= '0;
            r_good_run  <= '0;
            r_bad_run   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_good_run  <= w_good_run_nxt;
            r_bad_run   <= w_bad_run_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_checker
//  Description : Directed self-checking bench for prbs_checker. Two instances
//                share stimulus: default counter width and a 2-bit counter
//                used to observe saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       clr_cnt = 1'b0;

    logic       locked_a, err_pulse_a;
    logic [7:0] err_count_a;
    logic       locked_b, err_pulse_b;
    logic [1:0] err_count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int p       = 0;

    // Reference period-15 sequence for TAPS=1001, starting at 0001.
    logic [3:0] seq [0:14] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    prbs_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a)
    );

    prbs_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, return just after the sampling rising edge.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_good();
        step(1'b1, seq[p], 1'b0);
        p = (p + 1) % 15;
    endtask

    task automatic send_bad();
        step(1'b1, seq[p] ^ 4'b0110, 1'b0);
        p = (p + 1) % 15;
    endtask

    initial begin
        // Reset with random valid data.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            check("rst_locked", locked_a, 0);
            check("rst_pulse", err_pulse_a, 0);
            check("rst_count", err_count_a, 0);
        end

        // Clean lock: seed + 4 matches, lock after 1110 is sampled.
        rst = 1'b0;
        p   = 0;
        for (int i = 0; i < 4; i++) send_good();
        check("lock_early", locked_a, 0);
        send_good();
        check("lock_rise", locked_a, 1);
        for (int i = 0; i < 30; i++) begin
            send_good();
            check("clean_pulse", err_pulse_a, 0);
        end
        check("clean_count", err_count_a, 0);
        check("clean_locked", locked_a, 1);

        // Single error: 0100 replaces 0101.
        while (p != 7) send_good();
        step(1'b1, 4'b0100, 1'b0);
        p = 8;
        check("single_pulse", err_pulse_a, 1);
        check("single_count", err_count_a, 1);
        check("single_locked", locked_a, 1);
        send_good();
        check("after_pulse", err_pulse_a, 0);
        check("after_count", err_count_a, 1);

        // Clear with no valid word.
        step(1'b0, 4'h0, 1'b1);
        check("clr_idle", err_count_a, 0);

        // Loss of lock after 3 consecutive errors, then reacquire.
        send_bad();
        check("loss1_count", err_count_a, 1);
        check("loss1_locked", locked_a, 1);
        send_bad();
        check("loss2_count", err_count_a, 2);
        check("loss2_locked", locked_a, 1);
        send_bad();
        check("loss3_count", err_count_a, 3);
        check("loss3_pulse", err_pulse_a, 1);
        check("loss3_locked", locked_a, 0);
        for (int i = 0; i < 4; i++) begin
            send_good();
            check("reacq_early", locked_a, 0);
            check("reacq_pulse", err_pulse_a, 0);
        end
        send_good();
        check("reacq_locked", locked_a, 1);
        check("reacq_count", err_count_a, 3);

        // Stall with garbage on data_in while locked.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            check("stall_pulse", err_pulse_a, 0);
            check("stall_locked", locked_a, 1);
        end
        for (int i = 0; i < 3; i++) begin
            send_good();
            check("resume_pulse", err_pulse_a, 0);
            check("resume_locked", locked_a, 1);
        end
        check("resume_count", err_count_a, 3);

        // Reset mid-lock drops lock on the next edge.
        rst = 1'b1;
        send_good();
        check("midrst_locked", locked_a, 0);
        check("midrst_count", err_count_a, 0);
        rst = 1'b0;

        // Zero words never seed.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'h0, 1'b0);
            check("zero_locked", locked_a, 0);
        end

        // Lock from a fresh stream, then saturation on the 2-bit counter.
        p = 3;
        for (int i = 0; i < 5; i++) send_good();
        check("sat_lock_a", locked_a, 1);
        check("sat_lock_b", locked_b, 1);
        for (int i = 0; i < 5; i++) begin
            send_bad();
            check("sat_pulse", err_pulse_b, 1);
            check("sat_count_b", err_count_b, (i < 3) ? i + 1 : 3);
            check("sat_count_a", err_count_a, i + 1);
            send_good();
            check("sat_gap_pulse", err_pulse_b, 0);
            check("sat_gap_locked", locked_b, 1);
        end
        // Clear coinciding with a sixth error.
        step(1'b1, seq[p] ^ 4'b0110, 1'b1);
        p = (p + 1) % 15;
        check("clr_err_count_b", err_count_b, 0);
        check("clr_err_count_a", err_count_a, 0);
        check("clr_err_pulse", err_pulse_b, 1);
        check("clr_err_locked", locked_b, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
